// File: rtl/inst_mem_block_responder.sv
// Instruction-bus read responder: one request fetches BLK_WORDS consecutive words
// from a fixed-latency synchronous memory and returns them as one packed block.
module inst_mem_block_responder #(
    parameter int BLK_WORDS = 4,
    parameter int MEM_LAT   = 1
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic [3:0]                 cpu_ren,
    input  logic [31:0]                cpu_raddr,
    output logic                       dev_rrdy,
    output logic                       dev_rvalid,
    output logic [32*BLK_WORDS-1:0]    dev_rdata,
    output logic                       mem_en,
    output logic [31:0]                mem_addr,
    input  logic [31:0]                mem_rdata
);

    localparam int CW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(BLK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t         state_reg;
    logic [CW-1:0]  issue_cnt_reg;
    logic [CW-1:0]  cap_cnt_reg;
    logic           mem_en_reg;
    logic [31:0]    mem_addr_reg;
    logic           dev_rvalid_reg;
    logic           ret_vld_reg [MEM_LAT];
    logic [31:0]    buf_reg     [BLK_WORDS];
    logic [31:0]    buf_next    [BLK_WORDS];
    logic [31:0]    rdata_reg   [BLK_WORDS];
    logic           ret_vld;
    logic           last_cap;

    assign ret_vld    = ret_vld_reg[MEM_LAT-1];
    assign last_cap   = ret_vld && (cap_cnt_reg == LAST_WORD);
    assign dev_rrdy   = (state_reg == IDLE);
    assign dev_rvalid = dev_rvalid_reg;
    assign mem_en     = mem_en_reg;
    assign mem_addr   = mem_addr_reg;

    // Valid shift register mirrors the memory pipeline so each return lands in the right word.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            ret_vld_reg[0] <= 1'b0;
        end else begin
            ret_vld_reg[0] <= mem_en_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < MEM_LAT; gi++) begin : g_ret
            always_ff @(posedge cpu_clk) begin
                if (cpu_rst) begin
                    ret_vld_reg[gi] <= 1'b0;
                end else begin
                    ret_vld_reg[gi] <= ret_vld_reg[gi-1];
                end
            end
        end

        for (gi = 0; gi < BLK_WORDS; gi++) begin : g_word
            assign buf_next[gi] = (ret_vld && (cap_cnt_reg == CW'(gi))) ? mem_rdata : buf_reg[gi];
            assign dev_rdata[32*gi +: 32] = rdata_reg[gi];

            always_ff @(posedge cpu_clk) begin
                if (cpu_rst) begin
                    buf_reg[gi]   <= 32'd0;
                    rdata_reg[gi] <= 32'd0;
                end else begin
                    buf_reg[gi] <= buf_next[gi];
                    // Snapshot includes the word arriving this cycle, so RESP needs no extra stage.
                    if (state_reg == DRAIN && last_cap) begin
                        rdata_reg[gi] <= buf_next[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_reg      <= IDLE;
            issue_cnt_reg  <= '0;
            cap_cnt_reg    <= '0;
            mem_en_reg     <= 1'b0;
            mem_addr_reg   <= 32'd0;
            dev_rvalid_reg <= 1'b0;
        end else begin
            if (ret_vld) begin
                cap_cnt_reg <= cap_cnt_reg + CW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (cpu_ren != 4'd0) begin
                        state_reg     <= ISSUE;
                        mem_en_reg    <= 1'b1;
                        mem_addr_reg  <= {cpu_raddr[31:2], 2'b00};
                        issue_cnt_reg <= '0;
                        cap_cnt_reg   <= '0;
                    end
                end
                ISSUE: begin
                    if (issue_cnt_reg == LAST_WORD) begin
                        mem_en_reg <= 1'b0;
                        state_reg  <= DRAIN;
                    end else begin
                        issue_cnt_reg <= issue_cnt_reg + CW'(1);
                        mem_addr_reg  <= mem_addr_reg + 32'd4;
                    end
                end
                DRAIN: begin
                    if (last_cap) begin
                        state_reg      <= RESP;
                        dev_rvalid_reg <= 1'b1;
                    end
                end
                RESP: begin
                    dev_rvalid_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_block_responder.sv
// Scoreboard bench: two responders (MEM_LAT=1 and MEM_LAT=3) share one request stream;
// expected memory addresses and response blocks are queued on acceptance and checked by a monitor.
module tb_inst_mem_block_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ren;
    logic [31:0]  raddr;

    logic         rrdy1, rvalid1, en1;
    logic [127:0] rdata1;
    logic [31:0]  addr1, mrd1;
    logic         rrdy3, rvalid3, en3;
    logic [127:0] rdata3;
    logic [31:0]  addr3, mrd3;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic prev_rst = 1'b0;

    typedef struct { logic [31:0] addr; int cyc; } aexp_t;
    typedef struct { logic [127:0] data; int cyc; } rexp_t;
    aexp_t aq [2][$];
    rexp_t rq [2][$];
    int    busy [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: word at byte address a holds 0xC0DE0000 ^ a
    // (0x1000 -> C0DE1000, 0xFFFFFFF8 -> 3F21FFF8, 0x0 -> C0DE0000).
    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    inst_mem_block_responder #(.BLK_WORDS(4), .MEM_LAT(1)) u1 (
        .cpu_clk(clk), .cpu_rst(rst), .cpu_ren(ren), .cpu_raddr(raddr),
        .dev_rrdy(rrdy1), .dev_rvalid(rvalid1), .dev_rdata(rdata1),
        .mem_en(en1), .mem_addr(addr1), .mem_rdata(mrd1));

    inst_mem_block_responder #(.BLK_WORDS(4), .MEM_LAT(3)) u3 (
        .cpu_clk(clk), .cpu_rst(rst), .cpu_ren(ren), .cpu_raddr(raddr),
        .dev_rrdy(rrdy3), .dev_rvalid(rvalid3), .dev_rdata(rdata3),
        .mem_en(en3), .mem_addr(addr3), .mem_rdata(mrd3));

    // Memory models; idle cycles return a poison word so stray captures show up.
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        mrd1  <= en1 ? memf(addr1) : 32'hDEAD_BEEF;
        p3[0] <= en3 ? memf(addr3) : 32'hDEAD_BEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mrd3 = p3[2];

    task automatic mon(input int id, input int lat, input logic rrdy, input logic rvalid,
                       input logic [127:0] rdata, input logic en, input logic [31:0] addr);
        aexp_t a;
        rexp_t r;
        logic [31:0] base;
        if (en) begin
            checks++;
            if (aq[id].size() == 0) begin
                errors++;
                $display("FAIL mem_en[lat%0d] cyc=%0d: unexpected read addr=%h, required none", lat, cyc, addr);
            end else begin
                a = aq[id].pop_front();
                if (addr !== a.addr || cyc != a.cyc) begin
                    errors++;
                    $display("FAIL mem_addr[lat%0d]: got %h at cyc %0d, required %h at cyc %0d", lat, addr, cyc, a.addr, a.cyc);
                end else
                    $display("ok   mem_addr[lat%0d] %h at cyc %0d", lat, addr, cyc);
            end
        end
        if (rvalid) begin
            checks++;
            if (rq[id].size() == 0) begin
                errors++;
                $display("FAIL rvalid[lat%0d] cyc=%0d: unexpected response, required none", lat, cyc);
            end else begin
                r = rq[id].pop_front();
                if (rdata !== r.data || cyc != r.cyc) begin
                    errors++;
                    $display("FAIL rdata[lat%0d]: got %h at cyc %0d, required %h at cyc %0d", lat, rdata, cyc, r.data, r.cyc);
                end else
                    $display("ok   rdata[lat%0d] %h at cyc %0d", lat, rdata, cyc);
            end
        end
        checks++;
        if (rrdy !== (busy[id] == 0)) begin
            errors++;
            $display("FAIL rrdy[lat%0d] cyc=%0d: got %b, required %b", lat, cyc, rrdy, busy[id] == 0);
        end
        if (prev_rst) begin
            checks++;
            if (rdata !== 128'd0 || en !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[lat%0d]: rdata=%h mem_en=%b, required 0 and 0", lat, rdata, en);
            end
        end
        // Reference model of acceptance and expected traffic.
        if (rst) begin
            busy[id] = 0;
            aq[id].delete();
            rq[id].delete();
        end else if (busy[id] == 0) begin
            if (ren != 4'd0) begin
                base = {raddr[31:2], 2'b00};
                r.data = '0;
                for (int k = 0; k < 4; k++) begin
                    a.addr = base + 32'(4 * k);
                    a.cyc  = cyc + 1 + k;
                    aq[id].push_back(a);
                    r.data[32*k +: 32] = memf(a.addr);
                end
                r.cyc = cyc + 4 + lat + 1;
                rq[id].push_back(r);
                busy[id] = 4 + lat + 1;
            end
        end else begin
            busy[id] = busy[id] - 1;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 1, rrdy1, rvalid1, rdata1, en1, addr1);
        mon(1, 3, rrdy3, rvalid3, rdata3, en3, addr3);
        prev_rst = rst;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] r, input logic [31:0] a);
        ren = r;
        raddr = a;
        step(1);
        ren = 4'd0;
    endtask

    initial begin
        busy[0] = 0;
        busy[1] = 0;
        rst = 1'b1;
        ren = 4'd0;
        raddr = 32'd0;
        step(3);
        rst = 1'b0;
        step(1);
        // Aligned refill
        req(4'hF, 32'h0000_1000);
        step(12);
        // Request held high across two fetches
        ren = 4'hF;
        raddr = 32'h0000_1000;
        step(1);
        raddr = 32'h0000_2000;
        step(12);
        ren = 4'd0;
        step(12);
        // Unaligned address, arbitrary nonzero ren
        req(4'h2, 32'h0000_1006);
        step(12);
        // Wrap-around at top of address space
        req(4'h1, 32'hFFFF_FFF8);
        step(12);
        // Abort in the middle of a fetch, then a fresh fetch
        req(4'hF, 32'h0000_1000);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        req(4'hF, 32'h0000_3000);
        step(14);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (aq[i].size() != 0 || rq[i].size() != 0) begin
                errors++;
                $display("FAIL drain[%0d]: pending addr=%0d resp=%0d, required 0 and 0", i, aq[i].size(), rq[i].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
